board_judge: RTL

BOARD_JUDGE -- requirements
Module: board_judge

---
 rtl/tictactoe_pkg.sv | 34 +++
 rtl/line_eval.sv | 15 +
 rtl/board_judge.sv | 92 +++++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types for the tic-tac-toe judge: cell marks, winner codes, FSM states
// and the table of the eight lines that are scanned in order.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PLAYER2 = 2'b10,
    PLAYER1 = 2'b11
  } cellStateType;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_TIE  = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_P1   = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} judge_state_t;

  // LINES[idx][k] is the k-th cell of line idx: rows, then columns, then diagonals.
  localparam logic [7:0][2:0][3:0] LINES = {
    {4'd6, 4'd4, 4'd2},
    {4'd8, 4'd4, 4'd0},
    {4'd8, 4'd5, 4'd2},
    {4'd7, 4'd4, 4'd1},
    {4'd6, 4'd3, 4'd0},
    {4'd8, 4'd7, 4'd6},
    {4'd5, 4'd4, 4'd3},
    {4'd2, 4'd1, 4'd0}
  };

  function automatic logic [1:0] cell_at(logic [17:0] b, logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/line_eval.sv
// Judges one line of three cells: a win needs three equal, non-empty marks.
module line_eval
  import tictactoe_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       win,
  output logic [1:0] code
);

  assign win  = (a != EMPTY) && (a == b) && (b == c);
  assign code = win ? a : WIN_NONE;

endmodule

// File: rtl/board_judge.sv
// Tic-tac-toe board register and judge: accepts one mark while idle, then scans
// the eight lines one per cycle to decide a win, a tie, or to keep playing.
module board_judge
  import tictactoe_pkg::*;
(
  input  logic        ph1,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic [1:0]  cellState,
  output logic [17:0] gBoard,
  output logic        gameIsDone,
  output logic [1:0]  winner,
  output logic        writeAck,
  output logic        writeNack,
  output logic        busy
);

  judge_state_t state;
  logic [2:0]   idx;
  logic         req, cell_free, full, lwin;
  logic [1:0]   ca, cb, cc, lcode;
  logic [3:0]   sel;

  assign req       = (addr <= 4'd8) && (cellState != EMPTY);
  assign sel       = req ? addr : 4'd0;
  assign cell_free = (cell_at(gBoard, sel) == EMPTY);
  assign busy      = (state != IDLE);

  assign ca = cell_at(gBoard, LINES[idx][0]);
  assign cb = cell_at(gBoard, LINES[idx][1]);
  assign cc = cell_at(gBoard, LINES[idx][2]);

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < 9; i++)
      if (cell_at(gBoard, 4'(i)) == EMPTY) full = 1'b0;
  end

  line_eval u_line (.a(ca), .b(cb), .c(cc), .win(lwin), .code(lcode));

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      gBoard     <= '0;
      winner     <= WIN_NONE;
      gameIsDone <= 1'b0;
      writeAck   <= 1'b0;
      writeNack  <= 1'b0;
    end else begin
      writeAck  <= 1'b0;
      writeNack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (cell_free) begin
              gBoard[{sel, 1'b0} +: 2] <= cellState;
              writeAck <= 1'b1;
              idx      <= 3'd0;
              state    <= SCAN;
            end else begin
              writeNack <= 1'b1;
            end
          end
        end
        SCAN: begin
          writeNack <= req;
          // A completed line outranks a full board, so win is checked first.
          if (lwin) begin
            winner     <= lcode;
            gameIsDone <= 1'b1;
            state      <= DONE;
          end else if (idx == 3'd7) begin
            if (full) begin
              winner     <= WIN_TIE;
              gameIsDone <= 1'b1;
              state      <= DONE;
            end else begin
              winner <= WIN_NONE;
              state  <= IDLE;
            end
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: writeNack <= req;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
